reg_file_ctrl: RTL and testbench



---
 rtl/reg_file_ctrl.sv | 112 +++++++++++
 tb/tb_reg_file_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_ctrl.sv
// Command-driven single-writer controller for a 1R/1W register file (WRITE/READ/ADD/COPY).
// Define RF_CTRL_SAT_EN to make ADD saturate at all-ones instead of wrapping.
module reg_file_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 1
) (
    input  logic              reset,
    input  logic              clock,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_COPY  = 2'b11;

    state_t            r_state;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_rsp_data;
    logic [DATA_W-1:0] w_add;

`ifdef RF_CTRL_SAT_EN
    logic [DATA_W:0] w_sum;
    assign w_sum = {1'b0, rf_rdata} + {1'b0, r_data};
    assign w_add = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
    assign w_add = rf_rdata + r_data;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_op       <= 2'b00;
            r_addr     <= '0;
            r_data     <= '0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_addr  <= cmd_addr;
                        r_data  <= cmd_data;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    // READ and ADD both return the value seen before any write lands
                    if (r_op == OP_READ || r_op == OP_ADD) begin
                        r_rsp_data <= rf_rdata;
                        r_state    <= RESP;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = r_rsp_data;
    assign rf_waddr  = r_addr;
    // COPY reads from the source address carried in the low data bits
    assign rf_raddr  = (r_op == OP_COPY) ? r_data[ADDR_W-1:0] : r_addr;

    always_comb begin
        rf_wen   = 1'b0;
        rf_wdata = '0;
        if (r_state == EXEC) begin
            case (r_op)
                OP_WRITE: begin
                    rf_wen   = 1'b1;
                    rf_wdata = r_data;
                end
                OP_ADD: begin
                    rf_wen   = 1'b1;
                    rf_wdata = w_add;
                end
                OP_COPY: begin
                    rf_wen   = 1'b1;
                    rf_wdata = rf_rdata;
                end
                default: begin
                    rf_wen   = 1'b0;
                    rf_wdata = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_ctrl.sv
// Self-checking bench for reg_file_ctrl: scoreboard of expected responses plus per-scenario checks.
module tb_reg_file_ctrl;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 1;

    logic              reset, clock;
    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rf_wen;
    logic [ADDR_W-1:0] rf_waddr, rf_raddr;
    logic [DATA_W-1:0] rf_wdata, rf_rdata;

    logic [DATA_W-1:0] rf_mem [2**ADDR_W];
    logic [DATA_W-1:0] exp_rf [2**ADDR_W];
    logic [DATA_W-1:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    reg_file_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .reset(reset), .clock(clock),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file the controller drives (not reset, so aborted writes are visible)
    initial for (int i = 0; i < 2**ADDR_W; i++) rf_mem[i] = '0;
    always @(posedge clock) if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;
    assign rf_rdata = rf_mem[rf_raddr];

    // Response monitor: pops the scoreboard at each handshake
    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            logic [DATA_W-1:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rsp_unexpected: got rsp_data=%h, required no response", rsp_data);
            end else begin
                e = exp_q.pop_front();
                if (rsp_data !== e)
                    $display("FAIL rsp_data: got %h, required %h", rsp_data, e);
                else begin
                    n_pass++;
                    $display("rsp ok: data=%h", rsp_data);
                end
            end
        end
    end

    // Presents one command at posedge+1 and returns in the EXEC cycle (posedge+1)
    task automatic send_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        while (!cmd_ready && n < 50) begin
            @(posedge clock); #1; n++;
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        $display("cmd op=%0d addr=%0d data=%h", op, a, d);
        if (n >= 50) begin
            n_checks++;
            $display("FAIL cmd_timeout: cmd_ready stayed %b, required 1", cmd_ready);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clock); #1; n++;
        end
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain_timeout: %0d responses pending, required 0", exp_q.size());
        else n_pass++;
        @(posedge clock); #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        send_cmd(2'b00, a, d);
        exp_rf[a] = d;
        @(posedge clock); #1;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        exp_q.push_back(exp_rf[a]);
        send_cmd(2'b01, a, '0);
        drain();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rf_wen, rf_waddr, rf_wdata, rf_raddr} !==
            {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0})
            $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h wen=%b wa=%b wd=%h ra=%b, required 1 0 0000 0 0 0000 0",
                     cmd_ready, rsp_valid, rsp_data, rf_wen, rf_waddr, rf_wdata, rf_raddr);
        else n_pass++;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_write_read();
        send_cmd(2'b00, 1'b0, 16'h1234);
        exp_rf[0] = 16'h1234;
        @(negedge clock);
        n_checks++;
        if ({rf_wen, rf_waddr, rf_wdata, rsp_valid} !== {1'b1, 1'b0, 16'h1234, 1'b0})
            $display("FAIL write_exec: got wen=%b wa=%b wd=%h rv=%b, required 1 0 1234 0",
                     rf_wen, rf_waddr, rf_wdata, rsp_valid);
        else n_pass++;
        @(posedge clock); #1;
        exp_q.push_back(exp_rf[0]);
        send_cmd(2'b01, 1'b0, '0);
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL read_n1_valid: got %b, required 0", rsp_valid);
        else n_pass++;
        @(posedge clock); #1;
        n_checks++;
        if (rsp_valid !== 1'b1) $display("FAIL read_n2_valid: got %b, required 1", rsp_valid);
        else n_pass++;
        drain();
    endtask

    task automatic test_add();
        logic [DATA_W-1:0] exp_sum;
`ifdef RF_CTRL_SAT_EN
        exp_sum = 16'hFFFF;
`else
        exp_sum = 16'h0001;
`endif
        do_write(1'b1, 16'hFFFF);
        exp_q.push_back(exp_rf[1]);
        send_cmd(2'b10, 1'b1, 16'h0002);
        exp_rf[1] = exp_sum;
        @(negedge clock);
        n_checks++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 1'b1, exp_sum})
            $display("FAIL add_exec: got wen=%b wa=%b wd=%h, required 1 1 %h",
                     rf_wen, rf_waddr, rf_wdata, exp_sum);
        else n_pass++;
        drain();
        do_read(1'b1);
    endtask

    task automatic test_copy();
        do_write(1'b0, 16'hA5A5);
        do_write(1'b1, 16'h0000);
        send_cmd(2'b11, 1'b1, 16'h0000);
        exp_rf[1] = exp_rf[0];
        @(negedge clock);
        n_checks++;
        if ({rf_raddr, rf_wen, rf_waddr, rf_wdata, rsp_valid} !== {1'b0, 1'b1, 1'b1, 16'hA5A5, 1'b0})
            $display("FAIL copy_exec: got ra=%b wen=%b wa=%b wd=%h rv=%b, required 0 1 1 a5a5 0",
                     rf_raddr, rf_wen, rf_waddr, rf_wdata, rsp_valid);
        else n_pass++;
        @(posedge clock); #1;
        do_read(1'b1);
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] held;
        rsp_ready = 1'b0;
        exp_q.push_back(exp_rf[0]);
        send_cmd(2'b01, 1'b0, '0);
        @(posedge clock); #1;
        held = rsp_data;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 1'b1; cmd_data = 16'h7777;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++;
            if ({rsp_valid, cmd_ready} !== 2'b10 || rsp_data !== held)
                $display("FAIL stall_%0d: got rv=%b rdy=%b rd=%h, required 1 0 %h",
                         i, rsp_valid, cmd_ready, rsp_data, held);
            else n_pass++;
            @(posedge clock); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, rf_wen} !== 3'b100)
            $display("FAIL stall_release: got rdy=%b rv=%b wen=%b, required 1 0 0",
                     cmd_ready, rsp_valid, rf_wen);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL stall_rsp: %0d pending, required 0", exp_q.size());
        else n_pass++;
        do_read(1'b1);
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 1'b1; cmd_data = 16'h00FF;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL b2b_n_ready: got %b, required 1", cmd_ready);
        else n_pass++;
        @(posedge clock); #1;
        exp_rf[1] = 16'h00FF;
        cmd_op = 2'b01; cmd_data = '0;
        exp_q.push_back(exp_rf[1]);
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL b2b_n1_ready: got %b, required 0", cmd_ready);
        else n_pass++;
        @(posedge clock); #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL b2b_n2_ready: got %b, required 1", cmd_ready);
        else n_pass++;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h00FF)
            $display("FAIL b2b_n4_rsp: got rv=%b rd=%h, required 1 00ff", rsp_valid, rsp_data);
        else n_pass++;
        drain();
    endtask

    task automatic test_reset_midop();
        do_write(1'b0, 16'h0000);
        send_cmd(2'b00, 1'b0, 16'hBEEF);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rf_wen, rf_waddr, rf_wdata, rf_raddr} !==
            {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0})
            $display("FAIL midop_reset: got rdy=%b rv=%b rd=%h wen=%b wa=%b wd=%h ra=%b, required 1 0 0000 0 0 0000 0",
                     cmd_ready, rsp_valid, rsp_data, rf_wen, rf_waddr, rf_wdata, rf_raddr);
        else n_pass++;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL midop_ready: got %b, required 1", cmd_ready);
        else n_pass++;
        do_read(1'b0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2**ADDR_W; i++) exp_rf[i] = '0;
        test_reset();
        test_write_read();
        test_add();
        test_copy();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL final_queue: %0d pending, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
